// File: rtl/param_data_memory_if.sv
// Access bus of the parameterised data memory: read/write requests in,
// registered read word plus status flags out.
// Ports: MemRead, MemWrite, Address, WriteData (master -> memory);
//        ReadData, ReadValid, Busy, AddrError (memory -> master).
interface param_data_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;
    logic              Busy;
    logic              AddrError;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, ReadValid, Busy, AddrError
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, ReadValid, Busy, AddrError
    );
endinterface

// File: rtl/param_data_memory.sv
// Single-port register-file memory that fills itself (zero or signed ramp) after reset.
// Latency: read data and ReadValid/AddrError appear one cycle after the request.
// Backpressure: none; requests arriving while Busy is high are silently dropped.
// Ports: CLK (rising-edge clock), ResetN (synchronous active-low reset),
//        bus (slave side of param_data_memory_if: requests in, ReadData/flags out).
module param_data_memory #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 32,
    parameter int INIT_MODE = 1
) (
    input  logic                  CLK,
    input  logic                  ResetN,
    param_data_memory_if.slave    bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HALF  = DEPTH / 2;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               aerr_q, aerr_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               addr_ok;
    logic [IDX_W-1:0]   addr_idx;
    logic [DATA_W-1:0]  fill_val;
    logic               mem_we;
    logic [IDX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    // Range check uses the full address, so aliases above DEPTH never hit a row.
    assign addr_ok  = (32'(bus.Address) < DEPTH);
    assign addr_idx = bus.Address[IDX_W-1:0];

    // Lower half counts up from 0, upper half counts down from 0 (wraps to all-ones).
    always_comb begin
        fill_val = '0;
        if (INIT_MODE == 1) begin
            if (cnt_q < IDX_W'(HALF)) begin
                fill_val = DATA_W'(cnt_q);
            end else begin
                fill_val = DATA_W'(HALF) - DATA_W'(cnt_q);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = fill_val;
        rdata_d   = '0;
        rvalid_d  = 1'b0;
        aerr_d    = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_we = 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.MemWrite && addr_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = addr_idx;
                    mem_wdata = bus.WriteData;
                end
                // Read samples the array before this edge's write lands: old data wins.
                if (bus.MemRead) begin
                    rvalid_d = 1'b1;
                    if (addr_ok) begin
                        rdata_d = mem_q[addr_idx];
                    end
                end
                aerr_d = (bus.MemRead || bus.MemWrite) && !addr_ok;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!ResetN) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            aerr_q   <= aerr_d;
        end
    end

    // Array has no reset of its own; the fill sequence rewrites every row.
    always_ff @(posedge CLK) begin
        if (ResetN && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ReadData  = rdata_q;
    assign bus.ReadValid = rvalid_q;
    assign bus.AddrError = aerr_q;
    // Reset term keeps Busy high while ResetN is held, even before the first edge.
    assign bus.Busy      = (state_q == ST_INIT) || !ResetN;

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 8, address width in bits.
REQ-003 SHALL provide parameter DEPTH, default 32, number of rows; legal range 2..2^ADDR_W, even.
REQ-004 SHALL provide parameter INIT_MODE, default 1; 0 = zero fill, 1 = signed ramp fill.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port ResetN  input  1  synchronous, active-low reset.
REQ-007 SHALL have port MemRead  input  1  read request, sampled at CLK rise.
REQ-008 SHALL have port MemWrite  input  1  write request, sampled at CLK rise.
REQ-009 SHALL have port Address  input  ADDR_W  row index for read and write.
REQ-010 SHALL have port WriteData  input  DATA_W  write word.
REQ-011 SHALL have port ReadData  output  DATA_W  registered read word.
REQ-012 SHALL have port ReadValid  output  1  ReadData qualifier, one-cycle pulse per accepted read.
REQ-013 SHALL have port Busy  output  1  high while initialisation sequence is running.
REQ-014 SHALL have port AddrError  output  1  one-cycle pulse on accepted access with Address >= DEPTH.

Function
REQ-015 SHALL implement a two-state FSM: INIT, IDLE.
REQ-016 In INIT, a row counter SHALL start at 0 and write one row per cycle, advancing by 1.
REQ-017 Fill value with INIT_MODE=1 SHALL be: row i < DEPTH/2 -> i; row i >= DEPTH/2 -> -(i - DEPTH/2), two's complement, truncated to DATA_W.
REQ-018 Fill value with INIT_MODE=0 SHALL be 0 for every row.
REQ-019 After writing row DEPTH-1, the FSM SHALL enter IDLE on the next edge; INIT lasts exactly DEPTH cycles after reset release.
REQ-020 Busy SHALL be 1 in INIT and 0 in IDLE.
REQ-021 In INIT, MemRead and MemWrite SHALL be ignored: no write, ReadValid=0, AddrError=0.
REQ-022 In IDLE, MemWrite=1 with Address < DEPTH SHALL update the row at the full Address value on that edge.
REQ-023 In IDLE, MemRead=1 SHALL assert ReadValid=1 for exactly the following cycle (latency 1), with ReadData = row contents.
REQ-024 ReadData SHALL be 0 in any cycle where ReadValid=0.
REQ-025 Simultaneous MemRead and MemWrite to the same row SHALL return the old (pre-write) data; the write SHALL take effect.
REQ-026 Access with Address >= DEPTH SHALL drop the write, and return ReadData=0 if read; AddrError=1 for the following cycle (with ReadValid=1 if read).
REQ-027 Back-to-back reads on consecutive cycles SHALL yield ReadValid high on consecutive cycles, one result per request, in order.

Reset
REQ-028 ResetN=0 at any rising edge SHALL force FSM to INIT, counter to 0, ReadData=0, ReadValid=0, AddrError=0, Busy=1.
REQ-029 Reset SHALL have priority over any access in the same cycle; that access SHALL be discarded.
REQ-030 Reset asserted mid-INIT or mid-IDLE SHALL restart the full DEPTH-cycle fill, overwriting all user-written data.
REQ-031 Busy SHALL remain 1 for the whole time ResetN is held low.

Verification
REQ-032 Defaults; release ResetN -> Busy=1 for 32 cycles then 0; reads of rows 5, 16, 17, 31 -> 0x05, 0x00, 0xFF, 0xF1, each one cycle after request with ReadValid=1.
REQ-033 Write 0xA5 to row 9, read row 9 next cycle -> ReadData=0xA5, ReadValid=1 one cycle after read; ReadData=0 the cycle after.
REQ-034 Same-cycle read+write row 3 with 0x77 -> ReadData=0x03; repeat read -> 0x77.
REQ-035 Write 0x55 to Address 40 -> AddrError pulse, all 32 rows unchanged; read Address 40 -> ReadData=0x00, ReadValid=1, AddrError=1.
REQ-036 Assert reads/writes during INIT -> ignored, no ReadValid; drop ResetN at counter=10 -> fill restarts, Busy stays high 32 cycles from release; a prior write to row 9 is restored to 0x09.
REQ-037 INIT_MODE=0, DATA_W=16, DEPTH=64 -> Busy high 64 cycles; every row reads 0x0000; write/read row 63 0xBEEF -> 0xBEEF.
